seven_segment_scan: RTL and testbench
=====================================

# seven_segment_scan

Parametrised multiplexed seven-segment display driver for decimal readouts. It converts a WIDTH-bit unsigned binary value to DIGITS decimal digits using a sequential shift-add-3 (double-dabble) converter. It blanks leading zeros, saturates out-of-range values, and time-multiplexes the digits onto one shared segment bus with a one-hot digit select. It supersedes the fixed two-digit, 0–31 combinational decoder for all multi-digit displays in the design.

## Interface
- WIDTH, 8: width of the binary input; legal range 1..20.
- DIGITS, 3: number of display digits; legal range 1..6.
- SCAN_DIV, 4: clocks each digit stays selected; must be ≥ 1.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- number  input  WIDTH  unsigned value to display; sampled only when a load is accepted.
- load  input  1  single-cycle request to convert and display `number`.
- busy  output  1  conversion in progress; loads are ignored while high.
- overflow  output  1  the last committed value exceeded 10^DIGITS−1.
- digit_sel  output  DIGITS  one-hot, active-high; bit 0 selects the ones digit.
- segments  output  7  segments {a,b,c,d,e,f,g}, active-high (1 = lit).

## Operation
- Segment codes:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011
  - blank=0000000
- FSM states:
  - IDLE:
    - On load=1, capture `number` into the shift register.
    - Clear the internal BCD accumulator.
    - Go to SHIFT.
  - SHIFT:
    - Runs exactly WIDTH cycles.
    - Each cycle, add 3 to every BCD nibble ≥ 5, then shift {BCD, binary} left by one.
    - After the WIDTH-th cycle, go to COMMIT.
  - COMMIT:
    - Runs one cycle.
    - If the captured value > 10^DIGITS−1, load all DIGITS display nibbles with 9 and set overflow=1.
    - Otherwise, load the low DIGITS nibbles and set overflow=0.
    - Go to IDLE.
- BCD accumulator width:
  - Must hold 2^WIDTH−1.
  - 4·ceil((WIDTH+2)/3) bits suffices.
- The display register holds the previous value throughout SHIFT; no partial results ever reach `segments`.
- Leading-zero blanking:
  - Digit k is blank when it and every higher digit are 0, for k ≥ 1.
  - Digit 0 is never blank.
  - Interior zeros are shown.
- Scanning:
  - A divider counts 0..SCAN_DIV−1.
  - On wrap, the digit index advances 0→1→…→DIGITS−1→0.
  - Scanning runs continuously, independent of the FSM.
- `digit_sel` and `segments` are registered and always change on the same edge, so a digit never shows another digit's pattern.
- When DIGITS=1, digit_sel stays at 1 permanently.

## Timing
- Reset values:
  - FSM = IDLE, busy=0, overflow=0.
  - Display register = 0, divider = 0, digit index = 0.
  - digit_sel = 0…01, segments = 1111110.
- Load accepted on edge T (busy was 0):
  - busy=1 from T+1 through T+WIDTH+1.
  - busy=0 at T+WIDTH+2.
- Display register and overflow update on the COMMIT edge (T+WIDTH+1).
- `segments` reflects the new value from the next edge where the corresponding digit is driven, no later than T+WIDTH+2.
- Latency from load to the ones digit being correct is WIDTH+2 cycles, provided digit 0 is selected then.
- Load while busy=1 is ignored; no queueing, and `number` is not resampled.
- A load coinciding with the COMMIT cycle is ignored.
- A load on the first IDLE cycle after COMMIT is accepted.
- Each digit_sel value is held for exactly SCAN_DIV cycles. The full frame lasts DIGITS·SCAN_DIV cycles.
- Reset asserted mid-conversion aborts immediately:
  - The display returns to 0.
  - The in-flight value is discarded.
  - No COMMIT occurs.

## Test plan
- Reset (defaults):
  - Stimulus: assert reset, release, observe 12 cycles.
  - Response: digit_sel cycles 001,010,100, each held 4 cycles.
  - Segments are 1111110 on 001 and 0000000 on 010 and 100.
  - busy=0, overflow=0.
- Load 42 (defaults):
  - busy high for exactly 9 cycles.
  - Afterwards: 001→1101101, 010→0110011, 100→0000000; overflow=0.
- Load 100 (defaults):
  - 001→1111110, 010→1111110, 100→0110000.
  - Interior zeros are lit.
- Overflow with DIGITS=2, WIDTH=8:
  - Load 255 → both digits 1110011, overflow=1.
  - Then load 7 → 01→1110000, 10→0000000, overflow=0.
- Load while busy (defaults):
  - Load 42, then load 99 three cycles later.
  - Only 42 is displayed; busy falls 9 cycles after the first load.
  - Load 99 on the first cycle after busy falls → 99 displayed.
- Reset mid-conversion:
  - Load 200, assert reset 4 cycles later.
  - busy=0 immediately; display shows 0 (001→1111110); overflow=0.

Source files
------------

// File: rtl/seven_segment_scan_if.sv
// ============================================================================
// seven_segment_scan_if : value/handshake/display bundle of the seven-segment
//                         scanner (master = value source, slave = driver)
// Revision 1.0
// ============================================================================
`default_nettype none

interface seven_segment_scan_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic [WIDTH-1:0]  number;
   logic              load;
   logic              busy;
   logic              overflow;
   logic [DIGITS-1:0] digit_sel;
   logic [6:0]        segments;

   modport master (
      output number, load,
      input  busy, overflow, digit_sel, segments
   );

   modport slave (
      input  number, load,
      output busy, overflow, digit_sel, segments
   );
endinterface

`default_nettype wire

// File: rtl/seven_segment_scan.sv
// ============================================================================
// seven_segment_scan : sequential double-dabble binary-to-BCD converter with
//                      leading-zero blanking, saturation and digit scanning
// Revision 1.0
// ============================================================================
`default_nettype none

module seven_segment_scan #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 4
) (
   input  wire logic           clk,
   input  wire logic           reset,
   seven_segment_scan_if.slave bus
);
   localparam int NBCD = (WIDTH + 4) / 3;
   localparam int NNIB = (NBCD > DIGITS) ? NBCD : DIGITS;
   localparam int BCDW = 4 * NNIB;
   localparam int CNTW = $clog2(WIDTH + 1);
   localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHIFT  = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [WIDTH-1:0]    bin_q, bin_d;
   logic [BCDW-1:0]     bcd_q, bcd_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic [4*DIGITS-1:0] disp_q, disp_d;
   logic                ovf_q, ovf_d;
   logic [DIVW-1:0]     div_q, div_d;
   logic [IDXW-1:0]     idx_q, idx_d;
   logic [DIGITS-1:0]   sel_q, sel_d;
   logic [6:0]          seg_q, seg_d;

   logic [BCDW-1:0]     w_bcd_adj;
   logic                w_too_big;
   logic [DIGITS-1:0]   w_blank;

   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    f_seg = 7'b1111110;
         4'd1:    f_seg = 7'b0110000;
         4'd2:    f_seg = 7'b1101101;
         4'd3:    f_seg = 7'b1111001;
         4'd4:    f_seg = 7'b0110011;
         4'd5:    f_seg = 7'b1011011;
         4'd6:    f_seg = 7'b1011111;
         4'd7:    f_seg = 7'b1110000;
         4'd8:    f_seg = 7'b1111111;
         4'd9:    f_seg = 7'b1110011;
         default: f_seg = 7'b0000000;
      endcase
   endfunction

   for (genvar n = 0; n < NNIB; n++) begin : g_adj
      assign w_bcd_adj[4*n +: 4] = (bcd_q[4*n +: 4] >= 4'd5) ? bcd_q[4*n +: 4] + 4'd3
                                                              : bcd_q[4*n +: 4];
   end

   // Any nonzero BCD nibble above the displayed ones means the value cannot be shown.
   if (NNIB > DIGITS) begin : g_hi
      assign w_too_big = |bcd_q[BCDW-1:4*DIGITS];
   end else begin : g_no_hi
      assign w_too_big = 1'b0;
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_blank
      if (k == 0) begin : g_ones
         assign w_blank[k] = 1'b0;
      end else begin : g_upper
         assign w_blank[k] = (disp_q[4*DIGITS-1:4*k] == '0);
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.load) begin
               bin_d   = bus.number;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            {bcd_d, bin_d} = {w_bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == CNTW'(WIDTH - 1)) begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            if (w_too_big) begin
               disp_d = {DIGITS{4'd9}};
               ovf_d  = 1'b1;
            end else begin
               disp_d = bcd_q[4*DIGITS-1:0];
               ovf_d  = 1'b0;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Select and pattern are computed from the same next index so they move together.
   always_comb begin
      div_d = div_q + 1'b1;
      idx_d = idx_q;
      if (div_q == DIVW'(SCAN_DIV - 1)) begin
         div_d = '0;
         idx_d = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      sel_d = DIGITS'(1) << idx_d;
      seg_d = w_blank[idx_d] ? 7'b0000000 : f_seg(disp_q[4*idx_d +: 4]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
         idx_q <= '0;
         sel_q <= DIGITS'(1);
         seg_q <= 7'b1111110;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
         sel_q <= sel_d;
         seg_q <= seg_d;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.overflow  = ovf_q;
   assign bus.digit_sel = sel_q;
   assign bus.segments  = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scan.sv
// ============================================================================
// tb_seven_segment_scan : directed self-checking bench (3-digit and 2-digit)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_seven_segment_scan;
   localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
   localparam logic [6:0] S4 = 7'b0110011, S7 = 7'b1110000, S9 = 7'b1110011;
   localparam logic [6:0] SB = 7'b0000000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   busy_tot0 = 0;
   int   busy_tot1 = 0;

   always #5 clk = ~clk;

   seven_segment_scan_if #(.WIDTH(8), .DIGITS(3)) ifc ();
   seven_segment_scan_if #(.WIDTH(8), .DIGITS(2)) ifc2 ();

   seven_segment_scan #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) u_dut (
      .clk(clk), .reset(reset), .bus(ifc)
   );
   seven_segment_scan #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4)) u_dut2 (
      .clk(clk), .reset(reset), .bus(ifc2)
   );

   always @(negedge clk) begin
      if (ifc.busy)  busy_tot0 <= busy_tot0 + 1;
      if (ifc2.busy) busy_tot1 <= busy_tot1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   function automatic logic get_busy(input bit which);
      return which ? ifc2.busy : ifc.busy;
   endfunction

   // Called at a negedge; returns at the following negedge with load low.
   task automatic pulse(input bit which, input logic [7:0] v);
      if (which) begin ifc2.number = v; ifc2.load = 1'b1; end
      else       begin ifc.number  = v; ifc.load  = 1'b1; end
      @(negedge clk);
      ifc.load  = 1'b0;
      ifc2.load = 1'b0;
   endtask

   task automatic wait_idle(input bit which, input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!get_busy(which)) begin done = 1'b1; break; end
         @(negedge clk);
      end
      chk({tag, "_idle_timeout"}, 32'(done), 32'd1);
   endtask

   task automatic check_digit(input bit which, input logic [2:0] sel,
                              input logic [6:0] exp, input string tag);
      bit found = 1'b0;
      logic [2:0] s;
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         s = which ? {1'b0, ifc2.digit_sel} : ifc.digit_sel;
         if (s == sel) begin found = 1'b1; break; end
      end
      chk({tag, "_sel_found"}, 32'(found), 32'd1);
      if (found) chk(tag, 32'(which ? ifc2.segments : ifc.segments), 32'(exp));
   endtask

   initial begin
      int b0;
      logic [2:0] esel;
      ifc.number = '0;  ifc.load = 1'b0;
      ifc2.number = '0; ifc2.load = 1'b0;

      // Reset state and free-running scan with the display at zero.
      repeat (3) @(negedge clk);
      chk("rst_sel", 32'(ifc.digit_sel), 32'b001);
      chk("rst_seg", 32'(ifc.segments), 32'(S0));
      chk("rst_busy", 32'(ifc.busy), 32'd0);
      chk("rst_ovf", 32'(ifc.overflow), 32'd0);
      chk("rst_sel2", 32'(ifc2.digit_sel), 32'b01);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i != 0) @(negedge clk);
         esel = 3'b001 << (i / 4);
         chk("scan_sel", 32'(ifc.digit_sel), 32'(esel));
         chk("scan_seg", 32'(ifc.segments), (i < 4) ? 32'(S0) : 32'(SB));
      end
      chk("scan_busy", 32'(ifc.busy), 32'd0);
      chk("scan_ovf", 32'(ifc.overflow), 32'd0);

      // 42
      b0 = busy_tot0;
      pulse(1'b0, 8'd42);
      wait_idle(1'b0, "l42");
      chk("l42_busy_len", 32'(busy_tot0 - b0), 32'd9);
      chk("l42_ovf", 32'(ifc.overflow), 32'd0);
      check_digit(1'b0, 3'b001, S2, "l42_d0");
      check_digit(1'b0, 3'b010, S4, "l42_d1");
      check_digit(1'b0, 3'b100, SB, "l42_d2");

      // 100: interior zeros stay lit
      pulse(1'b0, 8'd100);
      wait_idle(1'b0, "l100");
      check_digit(1'b0, 3'b001, S0, "l100_d0");
      check_digit(1'b0, 3'b010, S0, "l100_d1");
      check_digit(1'b0, 3'b100, S1, "l100_d2");

      // Load while busy is dropped; load right after busy falls is taken.
      b0 = busy_tot0;
      pulse(1'b0, 8'd42);
      repeat (2) @(negedge clk);
      pulse(1'b0, 8'd99);
      wait_idle(1'b0, "lbusy");
      chk("lbusy_busy_len", 32'(busy_tot0 - b0), 32'd9);
      pulse(1'b0, 8'd99);
      chk("l99_accepted", 32'(ifc.busy), 32'd1);
      check_digit(1'b0, 3'b010, S4, "l99_hold_prev");
      wait_idle(1'b0, "l99");
      check_digit(1'b0, 3'b001, S9, "l99_d0");
      check_digit(1'b0, 3'b010, S9, "l99_d1");
      check_digit(1'b0, 3'b100, SB, "l99_d2");

      // Two-digit saturation and recovery.
      b0 = busy_tot1;
      pulse(1'b1, 8'd255);
      wait_idle(1'b1, "o255");
      chk("o255_busy_len", 32'(busy_tot1 - b0), 32'd9);
      chk("o255_ovf", 32'(ifc2.overflow), 32'd1);
      check_digit(1'b1, 3'b001, S9, "o255_d0");
      check_digit(1'b1, 3'b010, S9, "o255_d1");
      pulse(1'b1, 8'd7);
      wait_idle(1'b1, "o7");
      chk("o7_ovf", 32'(ifc2.overflow), 32'd0);
      check_digit(1'b1, 3'b001, S7, "o7_d0");
      check_digit(1'b1, 3'b010, SB, "o7_d1");

      // Reset mid-conversion aborts and clears the display.
      pulse(1'b0, 8'd200);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mrst_busy", 32'(ifc.busy), 32'd0);
      chk("mrst_ovf", 32'(ifc.overflow), 32'd0);
      chk("mrst_sel", 32'(ifc.digit_sel), 32'b001);
      chk("mrst_seg", 32'(ifc.segments), 32'(S0));
      @(negedge clk);
      reset = 1'b0;
      check_digit(1'b0, 3'b010, SB, "mrst_d1");
      check_digit(1'b0, 3'b001, S0, "mrst_d0");
      chk("mrst_idle", 32'(ifc.busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
